scalar_product_seq: RTL and testbench

Sequential, lane-parallel dot product of two unsigned vectors of SIZE_ARRAY elements.
- Consumes LANES element pairs per accepted beat over a valid/ready stream and accumulates their products.
- Presents the SIZE_INT-bit result over a valid/ready output handshake.
- Replaces the fully combinational adder-tree scalar product where area matters more than single-cycle latency; sits between the vector buffers and the result consumer.

---
 rtl/scalar_product_seq.sv | 121 ++++++++++++
 tb/tb_scalar_product_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_product_seq.sv
// Sequential lane-parallel unsigned dot product with valid/ready input and output handshakes.
// Define SCALAR_PRODUCT_SAT_EN to saturate the result instead of truncating it.
module scalar_product_seq #(
    parameter int SIZE_ARRAY = 256,
    parameter int SIZE_INT   = 32,
    parameter int LANES      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*SIZE_INT-1:0] IX,
    input  logic [LANES*SIZE_INT-1:0] IY,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SIZE_INT-1:0]       result,
    output logic                      busy
);

    localparam int BEATS  = SIZE_ARRAY / LANES;
    localparam int ACC_W  = 2 * SIZE_INT + $clog2(SIZE_ARRAY);
    localparam int PROD_W = 2 * SIZE_INT;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [SIZE_INT-1:0] result_q, result_d;

    logic [PROD_W-1:0]   prod [LANES];
    logic [ACC_W-1:0]    beat_sum;
    logic [ACC_W-1:0]    acc_sum;
    logic [SIZE_INT-1:0] result_fmt;
    logic                last_beat;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign prod[gi] = PROD_W'(IX[gi*SIZE_INT +: SIZE_INT]) * PROD_W'(IY[gi*SIZE_INT +: SIZE_INT]);
        end
    endgenerate

    always_comb begin
        beat_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            beat_sum = beat_sum + ACC_W'(prod[k]);
        end
    end

    assign acc_sum   = acc_q + beat_sum;
    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

`ifdef SCALAR_PRODUCT_SAT_EN
    // Any bit above the result width means the sum exceeds the representable maximum.
    assign result_fmt = (|acc_sum[ACC_W-1:SIZE_INT]) ? '1 : acc_sum[SIZE_INT-1:0];
`else
    assign result_fmt = acc_sum[SIZE_INT-1:0];
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        if (clr) begin
            // Abort wins over everything, including a beat presented this cycle.
            state_d  = ACCUM;
            cnt_d    = '0;
            acc_d    = '0;
            result_d = '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        if (last_beat) begin
                            result_d = result_fmt;
                            acc_d    = '0;
                            cnt_d    = '0;
                            state_d  = DONE;
                        end else begin
                            acc_d = acc_sum;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ACCUM;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == DONE) || (cnt_q != '0);
    assign result    = result_q;

endmodule

// File: tb/tb_scalar_product_seq.sv
// Bench for scalar_product_seq: directed scenarios on a small instance, random traffic on
// both a small and a wide single-lane instance, all checked by a per-cycle behavioural model.
module tb_scalar_product_seq;

    localparam int A_SA = 8, A_SI = 8, A_L = 4, A_BEATS = A_SA / A_L;
    localparam int B_SA = 256, B_SI = 32, B_L = 1, B_BEATS = B_SA / B_L;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                  a_clr, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [A_L*A_SI-1:0]   a_IX, a_IY;
    logic [A_SI-1:0]       a_result;
    logic                  b_clr, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [B_L*B_SI-1:0]   b_IX, b_IY;
    logic [B_SI-1:0]       b_result;

    scalar_product_seq #(.SIZE_ARRAY(A_SA), .SIZE_INT(A_SI), .LANES(A_L)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(a_clr), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .IX(a_IX), .IY(a_IY), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .result(a_result), .busy(a_busy)
    );

    scalar_product_seq #(.SIZE_ARRAY(B_SA), .SIZE_INT(B_SI), .LANES(B_L)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(b_clr), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .IX(b_IX), .IY(b_IY), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .result(b_result), .busy(b_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Final value from the full mathematical sum: truncated, or clamped when saturating.
    function automatic logic [63:0] fmt(input logic [127:0] s, input int w);
        logic [127:0] lim;
        logic [127:0] tmp;
        lim = (128'd1 << w) - 128'd1;
`ifdef SCALAR_PRODUCT_SAT_EN
        tmp = (s > lim) ? lim : s;
`else
        tmp = s & lim;
`endif
        return tmp[63:0];
    endfunction

    // Behavioural model: a pending flag, beats gathered so far, the exact running sum.
    bit           a_pend, b_pend;
    int           a_beats, b_beats, b_done;
    logic [127:0] a_sum, b_sum;
    logic [63:0]  a_exp, b_exp;

    initial begin
        b_done = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                a_pend = 0; a_beats = 0; a_sum = '0; a_exp = '0;
                b_pend = 0; b_beats = 0; b_sum = '0; b_exp = '0;
            end
            check("a_in_ready",  64'(a_in_ready),  64'(!a_pend));
            check("a_out_valid", 64'(a_out_valid), 64'(a_pend));
            check("a_busy",      64'(a_busy),      64'(a_pend || a_beats != 0));
            check("a_result",    64'(a_result),    a_exp);
            check("b_in_ready",  64'(b_in_ready),  64'(!b_pend));
            check("b_out_valid", 64'(b_out_valid), 64'(b_pend));
            check("b_busy",      64'(b_busy),      64'(b_pend || b_beats != 0));
            check("b_result",    64'(b_result),    b_exp);
            if (rst_n) begin
                if (a_clr) begin
                    a_pend = 0; a_beats = 0; a_sum = '0; a_exp = '0;
                end else if (a_pend) begin
                    if (a_out_ready) a_pend = 0;
                end else if (a_in_valid) begin
                    for (int k = 0; k < A_L; k++)
                        a_sum = a_sum + 128'(a_IX[k*A_SI +: A_SI]) * 128'(a_IY[k*A_SI +: A_SI]);
                    a_beats++;
                    if (a_beats == A_BEATS) begin
                        a_exp = fmt(a_sum, A_SI); a_pend = 1; a_beats = 0; a_sum = '0;
                    end
                end
                if (b_clr) begin
                    b_pend = 0; b_beats = 0; b_sum = '0; b_exp = '0;
                end else if (b_pend) begin
                    if (b_out_ready) b_pend = 0;
                end else if (b_in_valid) begin
                    for (int k = 0; k < B_L; k++)
                        b_sum = b_sum + 128'(b_IX[k*B_SI +: B_SI]) * 128'(b_IY[k*B_SI +: B_SI]);
                    b_beats++;
                    if (b_beats == B_BEATS) begin
                        b_exp = fmt(b_sum, B_SI); b_pend = 1; b_beats = 0; b_sum = '0;
                        b_done++;
                        $display("vector B#%0d complete, expected result %0d", b_done, b_exp);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] x, input logic [31:0] y);
        a_in_valid = 1'b1;
        a_IX = x;
        a_IY = y;
        step();
    endtask

    task automatic idle();
        a_in_valid = 1'b0;
        step();
    endtask

    task automatic vec_lit(input string name, input logic [31:0] x0, input logic [31:0] x1,
                           input logic [31:0] y0, input logic [31:0] y1, input logic [7:0] exp);
        beat(x0, y0);
        check({name, "_mid_ov"}, 64'(a_out_valid), 64'd0);
        beat(x1, y1);
        a_in_valid = 1'b0;
        check({name, "_ov"}, 64'(a_out_valid), 64'd1);
        check({name, "_res"}, 64'(a_result), 64'(exp));
        $display("vector %s: result %0d (expected %0d)", name, a_result, exp);
    endtask

    initial begin
        a_clr = 0; a_in_valid = 0; a_IX = '0; a_IY = '0; a_out_ready = 1;
        b_clr = 0; b_in_valid = 0; b_IX = '0; b_IY = '0; b_out_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(a_in_ready), 64'd1);
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_result", 64'(a_result), 64'd0);
        rst_n = 1'b1;
        step();

        // Basic: X=1..8, Y=1, then a second vector with in_valid held through DONE.
        vec_lit("basic", 32'h04030201, 32'h08070605, 32'h01010101, 32'h01010101, 8'd36);
        check("basic_in_ready_done", 64'(a_in_ready), 64'd0);
        a_in_valid = 1'b1; a_IX = 32'h02020202; a_IY = 32'h03030303;
        step();
        check("basic_back_ready", 64'(a_in_ready), 64'd1);
        check("basic_back_busy", 64'(a_busy), 64'd0);
        vec_lit("back2back", 32'h02020202, 32'h02020202, 32'h03030303, 32'h03030303, 8'd48);
        idle();

        // Gaps: one idle cycle between the two beats.
        beat(32'h02020202, 32'h03030303);
        idle();
        check("gap_busy", 64'(a_busy), 64'd1);
        check("gap_ov", 64'(a_out_valid), 64'd0);
        beat(32'h02020202, 32'h03030303);
        a_in_valid = 1'b0;
        check("gap_res", 64'(a_result), 64'd48);
        idle();

        // Wrap vs saturate on the largest operands.
`ifdef SCALAR_PRODUCT_SAT_EN
        vec_lit("maxval", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'd255);
`else
        vec_lit("maxval", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'd8);
`endif
        idle();

        // Backpressure: result and handshake frozen, offered beats ignored.
        a_out_ready = 1'b0;
        vec_lit("bp", 32'h04030201, 32'h08070605, 32'h02020202, 32'h02020202, 8'd72);
        for (int i = 0; i < 5; i++) begin
            a_in_valid = 1'b1; a_IX = $urandom; a_IY = $urandom;
            step();
            check("bp_hold_ov", 64'(a_out_valid), 64'd1);
            check("bp_hold_ready", 64'(a_in_ready), 64'd0);
            check("bp_hold_res", 64'(a_result), 64'd72);
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        step();
        check("bp_release_ready", 64'(a_in_ready), 64'd1);
        check("bp_release_busy", 64'(a_busy), 64'd0);

        // clr after one beat discards the partial sum.
        beat(32'h05050505, 32'h05050505);
        a_in_valid = 1'b0; a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        check("clr_busy", 64'(a_busy), 64'd0);
        check("clr_res", 64'(a_result), 64'd0);
        vec_lit("after_clr", 32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101, 8'd8);
        idle();

        // clr coinciding with a beat: the beat is dropped.
        a_clr = 1'b1; a_in_valid = 1'b1; a_IX = 32'h09090909; a_IY = 32'h09090909;
        check("clr_beat_ready", 64'(a_in_ready), 64'd1);
        step();
        a_clr = 1'b0; a_in_valid = 1'b0;
        check("clr_beat_busy", 64'(a_busy), 64'd0);
        vec_lit("clr_beat", 32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101, 8'd8);
        idle();

        // clr while a result is pending.
        a_out_ready = 1'b0;
        vec_lit("clr_done", 32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101, 8'd8);
        a_clr = 1'b1;
        step();
        a_clr = 1'b0; a_out_ready = 1'b1;
        check("clr_done_ov", 64'(a_out_valid), 64'd0);
        check("clr_done_res", 64'(a_result), 64'd0);

        // Asynchronous reset after one beat.
        beat(32'h07070707, 32'h07070707);
        a_in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ov", 64'(a_out_valid), 64'd0);
        check("arst_res", 64'(a_result), 64'd0);
        check("arst_busy", 64'(a_busy), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        vec_lit("after_rst", 32'h04030201, 32'h08070605, 32'h01010101, 32'h01010101, 8'd36);
        idle();

        // Random traffic on the small instance.
        for (int i = 0; i < 400; i++) begin
            a_in_valid  = ($urandom_range(3) != 0);
            a_IX        = $urandom;
            a_IY        = $urandom;
            a_out_ready = ($urandom_range(2) != 0);
            a_clr       = ($urandom_range(39) == 0);
            step();
        end
        a_in_valid = 1'b0; a_clr = 1'b0; a_out_ready = 1'b1;
        step();

        // Wide single-lane instance: 100 random vectors.
        for (int i = 0; i < 60000 && b_done < 100; i++) begin
            b_in_valid  = ($urandom_range(7) != 0);
            b_IX        = $urandom;
            b_IY        = $urandom;
            b_out_ready = ($urandom_range(3) != 0);
            step();
        end
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        check("b_vectors_done", 64'(b_done >= 100), 64'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
